// File: rtl/float16_sub_pipe.sv
// Three-stage binary16 subtractor (a - b, round-to-nearest-even) with a valid/ready
// handshake and a pass-through tag; special operands bypass the arithmetic path.
module float16_sub_pipe #(
    parameter int TAG_W     = 4,
    parameter int FLOAT_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLOAT_LEN-1:0] in_a,
    input  logic [FLOAT_LEN-1:0] in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FLOAT_LEN-1:0] out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic [2:0]           out_flags
);

    function automatic logic [4:0] eff_exp(input logic [4:0] e);
        return (e == 5'd0) ? 5'd1 : e;
    endfunction

    function automatic logic [5:0] lzc14(input logic [13:0] v);
        lzc14 = 6'd14;
        for (int i = 0; i < 14; i++)
            if (v[i]) lzc14 = 6'(13 - i);
    endfunction

    // n = {hidden, mantissa[9:0], G, R, S}; returns {overflow, underflow, result}
    function automatic logic [17:0] rne_pack(input logic sign, input logic [5:0] ex,
                                             input logic [13:0] n);
        logic        up;
        logic [11:0] r;
        logic [5:0]  e;
        logic [9:0]  m;
        up = n[2] & (n[1] | n[0] | n[3]);
        r  = {1'b0, n[13:3]} + {11'd0, up};
        if (r[11]) begin
            e = ex + 6'd1;
            m = r[10:1];
        end else begin
            e = r[10] ? ex : 6'd0;
            m = r[9:0];
        end
        if (e >= 6'd31)
            rne_pack = {2'b10, sign, 5'h1F, 10'h000};
        else
            rne_pack = {1'b0, (e == 6'd0) & (|n[2:0]), sign, e[4:0], m};
    endfunction

    logic        advance;
    logic        vld_p0, vld_p1, vld_p2;

    logic        swap_c, sign_c, sub_c, spec_c, inv_c;
    logic [14:0] lg_fp_c, sm_fp_c;
    logic [4:0]  lg_exp_c, sm_exp_c, exp_diff_c;
    logic [10:0] sm_sig_c;
    logic [27:0] sm_wide_c;
    logic [13:0] sm_align_c;
    logic [15:0] spec_res_c;
    logic        a_nan, b_nan, a_inf, b_inf;

    logic             sign_p0, sub_p0, spec_p0, inv_p0;
    logic [4:0]       exp_p0;
    logic [13:0]      lg_p0, sm_p0;
    logic [15:0]      spec_res_p0;
    logic [TAG_W-1:0] tag_p0;

    logic [14:0] sum_c;
    logic        sum_sign_c;

    logic             sign_p1, spec_p1, inv_p1;
    logic [4:0]       exp_p1;
    logic [14:0]      sum_p1;
    logic [15:0]      spec_res_p1;
    logic [TAG_W-1:0] tag_p1;

    logic [5:0]  lz_c, shamt_c, nexp_c;
    logic [13:0] norm_c;
    logic [17:0] packed_c;
    logic [15:0] res_c;
    logic [2:0]  flags_c;

    logic [15:0]      result_p2;
    logic [TAG_W-1:0] tag_p2;
    logic [2:0]       flags_p2;

    assign advance    = ~vld_p2 | out_ready;
    assign in_ready   = advance;
    assign out_valid  = vld_p2;
    assign out_result = result_p2;
    assign out_tag    = tag_p2;
    assign out_flags  = flags_p2;

    // Stage 1: unpack, order by magnitude, align the smaller operand, classify specials
    always_comb begin
        swap_c     = in_b[14:0] > in_a[14:0];
        lg_fp_c    = swap_c ? in_b[14:0] : in_a[14:0];
        sm_fp_c    = swap_c ? in_a[14:0] : in_b[14:0];
        sign_c     = swap_c ? ~in_b[15] : in_a[15];
        sub_c      = in_a[15] ^ ~in_b[15];
        lg_exp_c   = eff_exp(lg_fp_c[14:10]);
        sm_exp_c   = eff_exp(sm_fp_c[14:10]);
        exp_diff_c = lg_exp_c - sm_exp_c;
        sm_sig_c   = {|sm_fp_c[14:10], sm_fp_c[9:0]};
        sm_wide_c  = {sm_sig_c, 3'b000, 14'd0} >> exp_diff_c;
        if (exp_diff_c >= 5'd14)
            sm_align_c = {13'd0, |sm_sig_c};
        else
            sm_align_c = {sm_wide_c[27:15], sm_wide_c[14] | (|sm_wide_c[13:0])};

        a_nan      = (&in_a[14:10]) & (|in_a[9:0]);
        b_nan      = (&in_b[14:10]) & (|in_b[9:0]);
        a_inf      = (&in_a[14:10]) & ~(|in_a[9:0]);
        b_inf      = (&in_b[14:10]) & ~(|in_b[9:0]);
        spec_c     = a_nan | b_nan | a_inf | b_inf;
        inv_c      = 1'b0;
        spec_res_c = 16'h7E00;
        if (a_nan | b_nan)
            spec_res_c = 16'h7E00;
        else if (a_inf & b_inf & (in_a[15] == in_b[15]))
            inv_c = 1'b1;
        else if (a_inf)
            spec_res_c = in_a;
        else if (b_inf)
            spec_res_c = {~in_b[15], in_b[14:0]};
    end

    // Stage 2: magnitude add or subtract; an exact cancellation yields +0
    always_comb begin
        if (sub_p0)
            sum_c = {1'b0, lg_p0} - {1'b0, sm_p0};
        else
            sum_c = {1'b0, lg_p0} + {1'b0, sm_p0};
        sum_sign_c = (sub_p0 && sum_c == 15'd0) ? 1'b0 : sign_p0;
    end

    // Stage 3: normalize (left shift clamped at exponent 1 for subnormals) and round
    always_comb begin
        lz_c = lzc14(sum_p1[13:0]);
        if (sum_p1[14]) begin
            shamt_c = 6'd0;
            norm_c  = {sum_p1[14:2], sum_p1[1] | sum_p1[0]};
            nexp_c  = {1'b0, exp_p1} + 6'd1;
        end else begin
            shamt_c = (lz_c < {1'b0, exp_p1}) ? lz_c : {1'b0, exp_p1} - 6'd1;
            norm_c  = sum_p1[13:0] << shamt_c;
            nexp_c  = {1'b0, exp_p1} - shamt_c;
        end
        packed_c = rne_pack(sign_p1, nexp_c, norm_c);
        if (spec_p1) begin
            res_c   = spec_res_p1;
            flags_c = {inv_p1, 2'b00};
        end else begin
            res_c   = packed_c[15:0];
            flags_c = {1'b0, packed_c[17:16]};
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            sign_p0     <= sign_c;
            sub_p0      <= sub_c;
            spec_p0     <= spec_c;
            inv_p0      <= inv_c;
            exp_p0      <= lg_exp_c;
            lg_p0       <= {|lg_fp_c[14:10], lg_fp_c[9:0], 3'b000};
            sm_p0       <= sm_align_c;
            spec_res_p0 <= spec_res_c;
            tag_p0      <= in_tag;

            sign_p1     <= sum_sign_c;
            spec_p1     <= spec_p0;
            inv_p1      <= inv_p0;
            exp_p1      <= exp_p0;
            sum_p1      <= sum_c;
            spec_res_p1 <= spec_res_p0;
            tag_p1      <= tag_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            result_p2 <= 16'h0000;
            tag_p2    <= '0;
            flags_p2  <= 3'b000;
        end else if (advance) begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            vld_p2    <= vld_p1;
            result_p2 <= res_c;
            tag_p2    <= tag_p1;
            flags_p2  <= flags_c;
        end
    end

endmodule

// File: tb/tb_float16_sub_pipe.sv
// Bench for float16_sub_pipe: directed vectors, backpressure, randomized streaming
// against an exact-integer reference model, and reset with operations in flight.
module tb_float16_sub_pipe;
    localparam int TAG_W = 4;

    logic             clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [15:0]      in_a, in_b, out_result;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [2:0]       out_flags;
    int               checks = 0;
    int               errors = 0;

    float16_sub_pipe #(.TAG_W(TAG_W), .FLOAT_LEN(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .out_flags(out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Exact result as an integer count of 2^-24 units, then rounded to nearest even.
    function automatic logic [18:0] ref_sub(input logic [15:0] a, input logic [15:0] b);
        int     ea, eb, p, sh;
        longint va, vb, d, m, q, rem, half;
        logic   s;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0)) return {3'b000, 16'h7E00};
        if (ea == 31 && eb == 31 && a[15] == b[15]) return {3'b100, 16'h7E00};
        if (ea == 31) return {3'b000, a};
        if (eb == 31) return {3'b000, ~b[15], b[14:0]};
        va = (ea == 0) ? longint'(a[9:0]) : (longint'(a[9:0]) + 1024) << (ea - 1);
        vb = (eb == 0) ? longint'(b[9:0]) : (longint'(b[9:0]) + 1024) << (eb - 1);
        d  = (a[15] ? -va : va) - (b[15] ? -vb : vb);
        if (d == 0) return (a == 16'h8000 && b == 16'h0000) ? 19'h08000 : 19'h00000;
        s = (d < 0);
        m = s ? -d : d;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        if (p < 10) return {3'b000, s, 5'd0, m[9:0]};
        sh  = p - 10;
        q   = m >> sh;
        rem = m - (q << sh);
        if (sh > 0) begin
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
        end
        if (q == 2048) begin
            q = 1024;
            sh++;
        end
        if (sh + 1 >= 31) return {3'b010, s, 5'h1F, 10'h000};
        return {3'b000, s, 5'(sh + 1), q[9:0]};
    endfunction

    function automatic logic [15:0] rand_op();
        return 16'($urandom);
    endfunction

    function automatic logic [15:0] rand_near(input logic [15:0] a);
        int e;
        e = int'(a[14:10]) + int'($urandom_range(0, 4)) - 2;
        if (e < 0) e = 0;
        if (e > 30) e = 30;
        return {1'($urandom), 5'(e), 10'($urandom)};
    endfunction

    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                           output logic [15:0] r, output logic [2:0] f,
                           output logic [3:0] ot, output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = t; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r = out_result; f = out_flags; ot = out_tag;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_result !== 16'h0000 || out_tag !== 4'h0 || out_flags !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b result=%h tag=%h flags=%b, required 0/0000/0/000",
                     out_valid, out_result, out_tag, out_flags);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [50:0] vec [10];
        logic [15:0] r;
        logic [2:0]  f;
        logic [3:0]  ot;
        int          lat;
        vec = '{{16'h4200, 16'h3C00, 16'h4000, 3'b000}, {16'h3C00, 16'h0C00, 16'h3C00, 3'b000},
                {16'h3C00, 16'h0A00, 16'h3C00, 3'b000}, {16'h3C00, 16'h3C00, 16'h0000, 3'b000},
                {16'h7C00, 16'h7C00, 16'h7E00, 3'b100}, {16'h7E01, 16'h3C00, 16'h7E00, 3'b000},
                {16'h3C00, 16'hFC00, 16'h7C00, 3'b000}, {16'h7BFF, 16'hFBFF, 16'h7C00, 3'b010},
                {16'h0400, 16'h0001, 16'h03FF, 3'b000}, {16'h0002, 16'h0001, 16'h0001, 3'b000}};
        for (int i = 0; i < 10; i++) begin
            run_one(vec[i][50:35], vec[i][34:19], 4'(i + 3), r, f, ot, lat);
            checks++;
            if (r !== vec[i][18:3]) begin
                errors++;
                $display("FAIL directed_result[%0d] %h-%h: got %h, required %h",
                         i, vec[i][50:35], vec[i][34:19], r, vec[i][18:3]);
            end
            checks++;
            if (f !== vec[i][2:0]) begin
                errors++;
                $display("FAIL directed_flags[%0d]: got %b, required %b", i, f, vec[i][2:0]);
            end
            checks++;
            if (ot !== 4'(i + 3)) begin
                errors++;
                $display("FAIL directed_tag[%0d]: got %h, required %h", i, ot, 4'(i + 3));
            end
            checks++;
            if (lat !== 3) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d, required 3", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] oa [5];
        logic [15:0] ob [5];
        logic [18:0] ex [5];
        int          sent, got, idx;
        sent = 0;
        got  = 0;
        for (int i = 0; i < 5; i++) begin
            oa[i] = rand_op();
            ob[i] = rand_near(oa[i]);
            ex[i] = ref_sub(oa[i], ob[i]);
        end
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clk);
            idx       = (sent < 5) ? sent : 0;
            in_valid  = (sent < 5);
            in_a      = oa[idx];
            in_b      = ob[idx];
            in_tag    = 4'(10 + idx);
            out_ready = (cyc >= 8);
            #1;
            if (cyc >= 3 && cyc < 8) begin
                checks++;
                if (in_ready !== 1'b0 || sent != 3 || out_valid !== 1'b1 ||
                    out_result !== ex[0][15:0] || out_tag !== 4'd10) begin
                    errors++;
                    $display("FAIL bp_hold cyc%0d: in_ready=%b accepted=%0d valid=%b result=%h tag=%h, required 0/3/1/%h/a",
                             cyc, in_ready, sent, out_valid, out_result, out_tag, ex[0][15:0]);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if ({out_flags, out_result} !== ex[got] || out_tag !== 4'(10 + got)) begin
                    errors++;
                    $display("FAIL bp_drain[%0d]: got %b/%h tag %h, required %b/%h tag %h", got,
                             out_flags, out_result, out_tag, ex[got][18:16], ex[got][15:0], 4'(10 + got));
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 5 || sent != 5) begin
            errors++;
            $display("FAIL bp_count: accepted %0d delivered %0d, required 5 and 5", sent, got);
        end
    endtask

    task automatic test_random();
        logic [18:0] q_exp [$];
        logic [3:0]  q_tag [$];
        logic [18:0] e;
        logic [3:0]  t;
        logic [15:0] a, b, held_r;
        logic [3:0]  held_t;
        logic        held_v;
        int          sent, got, cyc;
        sent = 0; got = 0; cyc = 0; held_v = 1'b0; held_r = '0; held_t = '0;
        while (got < 300 && cyc < 4000) begin
            @(negedge clk);
            if (held_v) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== held_r || out_tag !== held_t) begin
                    errors++;
                    $display("FAIL rand_stable: valid=%b result=%h tag=%h, required 1/%h/%h",
                             out_valid, out_result, out_tag, held_r, held_t);
                end
            end
            a = rand_op();
            b = ($urandom_range(0, 1) == 0) ? rand_op() : rand_near(a);
            in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
            in_a      = a;
            in_b      = b;
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q_exp.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: unexpected result %h tag %h", out_result, out_tag);
                end else begin
                    e = q_exp.pop_front();
                    t = q_tag.pop_front();
                    if ({out_flags, out_result} !== e || out_tag !== t) begin
                        errors++;
                        $display("FAIL rand_result[%0d]: got %b/%h tag %h, required %b/%h tag %h",
                                 got, out_flags, out_result, out_tag, e[18:16], e[15:0], t);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q_exp.push_back(ref_sub(a, b));
                q_tag.push_back(in_tag);
                sent++;
            end
            held_v = out_valid && !out_ready;
            held_r = out_result;
            held_t = out_tag;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 300 || q_exp.size() != 0) begin
            errors++;
            $display("FAIL rand_count: delivered %0d with %0d pending, required 300 and 0", got, q_exp.size());
        end
    endtask

    task automatic test_reset_inflight();
        logic [15:0] r;
        logic [2:0]  f;
        logic [3:0]  ot;
        int          lat, stale;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_a = 16'h4200; in_b = 16'h3C00; in_tag = 4'd5;
        @(negedge clk);
        in_a = 16'h3C00; in_b = 16'h0C00; in_tag = 4'd6;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL inflight_valid: got %b, required 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 16'h0000 || out_tag !== 4'h0 || out_flags !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: valid=%b result=%h tag=%h flags=%b, required 0/0000/0/000",
                     out_valid, out_result, out_tag, out_flags);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_one(16'h4400, 16'h3C00, 4'd9, r, f, ot, lat);
        checks++;
        if (r !== 16'h4200 || f !== 3'b000 || ot !== 4'd9 || lat !== 3) begin
            errors++;
            $display("FAIL post_reset_op: result=%h flags=%b tag=%h latency=%0d, required 4200/000/9/3",
                     r, f, ot, lat);
        end
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL stale_after_reset: %0d valid cycles seen, required 0", stale);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
